// File: rtl/valet_dispatch_arbiter_if.sv
// Request/grant bus between the gate/retrieval requesters, the dispatch arbiter and the valet FSM.
// Handshake: a requester holds valid and data until it sees its ready strobe; ready only asserts
// while valid is high, and a transfer completes on the edge where both are high.
interface valet_dispatch_arbiter_if #(
  parameter int NUM_GATES    = 4,
  parameter int PKT_W        = 32,
  parameter int REQ_W        = 16,
  parameter int STARVE_LIMIT = 4
);
  localparam int GW = $clog2(NUM_GATES);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [NUM_GATES-1:0]       arr_valid;
  logic [NUM_GATES*PKT_W-1:0] arr_data;
  logic [NUM_GATES-1:0]       arr_ready;
  logic                       ret_valid;
  logic [REQ_W-1:0]           ret_data;
  logic                       ret_ready;
  logic                       arrival_valid;
  logic [PKT_W-1:0]           arrival_info;
  logic                       retrieval_valid;
  logic [REQ_W-1:0]           retrieval_info;
  logic                       valet_ready;
  logic [GW-1:0]              grant_gate;
  logic [1:0]                 dbg_state;
  logic [GW-1:0]              dbg_rr_ptr;
  logic [CW-1:0]              dbg_starve_cnt;

  modport slave (
    input  arr_valid, arr_data, ret_valid, ret_data, valet_ready,
    output arr_ready, ret_ready, arrival_valid, arrival_info,
           retrieval_valid, retrieval_info, grant_gate,
           dbg_state, dbg_rr_ptr, dbg_starve_cnt
  );

  modport master (
    output arr_valid, arr_data, ret_valid, ret_data, valet_ready,
    input  arr_ready, ret_ready, arrival_valid, arrival_info,
           retrieval_valid, retrieval_info, grant_gate,
           dbg_state, dbg_rr_ptr, dbg_starve_cnt
  );
endinterface

// File: rtl/valet_dispatch_arbiter.sv
// Arbitrates NUM_GATES arrival gates and one retrieval queue into a one-entry holding register
// feeding the valet FSM. Optional VIP arrival bypass is enabled by defining VALET_VIP_BYPASS_EN.
module valet_dispatch_arbiter #(
  parameter int NUM_GATES    = 4,
  parameter int PKT_W        = 32,
  parameter int REQ_W        = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int VIP_BIT      = 31
) (
  input  logic                   clk,
  input  logic                   rst_n,
  valet_dispatch_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_GATES);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
`ifdef VALET_VIP_BYPASS_EN
  localparam bit VIP_EN = 1'b1;
`else
  localparam bit VIP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD_ARR = 2'd1, HOLD_RET = 2'd2} state_t;

  state_t               state, state_d;
  logic [GW-1:0]        rr_ptr, grant_idx, grant_gate;
  logic [CW-1:0]        starve_cnt;
  logic [NUM_GATES-1:0] vip_mask, arr_ready_c;
  logic                 accept, arr_any, vip_any, force_arr, grant_arr, grant_ret;
  logic [PKT_W-1:0]     arrival_info, sel_pkt;
  logic [REQ_W-1:0]     retrieval_info;

  // First requester at or after ptr, wrapping past the last gate.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_GATES-1:0] req,
                                            input logic [GW-1:0] ptr);
    logic [GW-1:0] cand;
    logic [GW-1:0] pick;
    logic          found;
    cand  = ptr;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_GATES; i++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
      cand = (cand == GW'(NUM_GATES - 1)) ? '0 : cand + GW'(1);
    end
    return pick;
  endfunction

  always_comb begin
    vip_mask = '0;
    for (int g = 0; g < NUM_GATES; g++)
      vip_mask[g] = VIP_EN & bus.arr_valid[g] & bus.arr_data[g*PKT_W + VIP_BIT];
    // Reset gates the accept window so no strobe escapes while rst_n is low.
    accept    = rst_n && ((state == IDLE) || bus.valet_ready);
    arr_any   = |bus.arr_valid;
    vip_any   = |vip_mask;
    force_arr = (starve_cnt == CW'(STARVE_LIMIT)) && arr_any;
    grant_arr = 1'b0;
    grant_ret = 1'b0;
    grant_idx = rr_pick(bus.arr_valid, rr_ptr);
    if (accept) begin
      if (vip_any) begin
        grant_arr = 1'b1;
        grant_idx = rr_pick(vip_mask, rr_ptr);
      end else if (bus.ret_valid && !force_arr) begin
        grant_ret = 1'b1;
      end else if (arr_any) begin
        grant_arr = 1'b1;
      end
    end

    state_d = state;
    if (grant_arr)      state_d = HOLD_ARR;
    else if (grant_ret) state_d = HOLD_RET;
    else if (accept)    state_d = IDLE;

    arr_ready_c = '0;
    if (grant_arr) arr_ready_c[grant_idx] = 1'b1;

    sel_pkt = '0;
    for (int g = 0; g < NUM_GATES; g++)
      if (grant_idx == GW'(g)) sel_pkt = bus.arr_data[g*PKT_W +: PKT_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arrival_info   <= '0;
      retrieval_info <= '0;
      rr_ptr         <= '0;
      grant_gate     <= '0;
      starve_cnt     <= '0;
    end else begin
      if (grant_arr) begin
        arrival_info <= sel_pkt;
        grant_gate   <= grant_idx;
        rr_ptr       <= (grant_idx == GW'(NUM_GATES - 1)) ? '0 : grant_idx + GW'(1);
      end
      if (grant_ret) retrieval_info <= bus.ret_data;
      if (!arr_any || grant_arr)
        starve_cnt <= '0;
      else if (grant_ret && starve_cnt != CW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + CW'(1);
    end
  end

  assign bus.arr_ready       = arr_ready_c;
  assign bus.ret_ready       = grant_ret;
  assign bus.arrival_valid   = (state == HOLD_ARR);
  assign bus.retrieval_valid = (state == HOLD_RET);
  assign bus.arrival_info    = arrival_info;
  assign bus.retrieval_info  = retrieval_info;
  assign bus.grant_gate      = grant_gate;
  assign bus.dbg_state       = state;
  assign bus.dbg_rr_ptr      = rr_ptr;
  assign bus.dbg_starve_cnt  = starve_cnt;
endmodule

// File: doc/valet_dispatch_arbiter.md
Name: valet_dispatch_arbiter

Overview:
Shares the single valet FSM request interface between NUM_GATES entrance gates (car arrivals) and one retrieval request queue. Retrievals have priority. An anti-starvation counter guarantees arrivals a grant after STARVE_LIMIT consecutive retrieval wins. Gates are served round-robin. The winner is captured in a one-entry holding register that drives the valet FSM's arrival/retrieval inputs until the FSM accepts it.

Parameters:
NUM_GATES, 4, number of arrival requesters (>=2)
PKT_W, 32, width of a packed car arrival packet
REQ_W, 16, width of a packed retrieval request
STARVE_LIMIT, 4, consecutive retrieval grants tolerated while any arrival is pending (>=1)
VIP_BIT, 31, bit index in the arrival packet flagging a VIP car (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  reset
arr_valid  in  NUM_GATES  per-gate arrival request
arr_data  in  NUM_GATES*PKT_W  per-gate arrival packets; gate g occupies bits [g*PKT_W +: PKT_W]
arr_ready  out  NUM_GATES  one-hot accept strobe per gate
ret_valid  in  1  retrieval request pending
ret_data  in  REQ_W  retrieval request
ret_ready  out  1  retrieval accept strobe
arrival_valid  out  1  to valet FSM: held arrival valid
arrival_info  out  PKT_W  to valet FSM: held arrival packet
retrieval_valid  out  1  to valet FSM: held retrieval valid
retrieval_info  out  REQ_W  to valet FSM: held retrieval request
valet_ready  in  1  valet FSM consumes the held request this cycle
grant_gate  out  $clog2(NUM_GATES)  index of the last granted gate (debug)

Behaviour:
- Clocking and reset: single clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: all valids 0, all readies 0, info registers 0, grant_gate 0, rr_ptr 0, starve_cnt 0, state IDLE.
- States:
  - IDLE: holding register empty.
  - HOLD_ARR: arrival_valid=1.
  - HOLD_RET: retrieval_valid=1.
  - arrival_valid and retrieval_valid are never 1 together.
- Accept window: accept = (state==IDLE) || (state!=IDLE && valet_ready). A combinational path from valet_ready to arr_ready/ret_ready is permitted.
- Selection (combinational, evaluated only when accept=1):
  - force_arr = (starve_cnt==STARVE_LIMIT) && |arr_valid.
  - ret_valid && !force_arr → grant retrieval.
  - Otherwise, if |arr_valid → grant the first valid gate searching from rr_ptr upward with wrap.
  - Otherwise → no grant.
- Ready strobes: exactly one of arr_ready[g] / ret_ready is high in a granting cycle; all are 0 otherwise. Readies never assert when accept=0.
- Capture and latency: a granted request is registered on the same edge. The output valid is high from the next cycle (latency 1). Info is held stable while valid=1 and valet_ready=0.
- Drain:
  - valet_ready=1 with no new grant → state IDLE, valids 0 next cycle.
  - Drain and grant in the same cycle → back-to-back; the holding register reloads, so throughput is 1 request per cycle.
- valet_ready while IDLE is ignored.
- Round-robin: after granting gate g, rr_ptr <= (g+1) mod NUM_GATES and grant_gate <= g. rr_ptr is unchanged on retrieval grants or no grant.
- Starvation counter (width $clog2(STARVE_LIMIT+1)):
  - Retrieval grant while |arr_valid → starve_cnt +1, saturating at STARVE_LIMIT.
  - Arrival grant → starve_cnt <= 0.
  - No arrival valid in a cycle → starve_cnt <= 0.
- Upstream holding: upstream requesters must hold valid/data until their ready. Dropping valid before ready is legal and simply withdraws the request.
- Reset mid-hold: the held request is discarded and is not replayed.

Optional Feature:
VALET_VIP_BYPASS_EN
- Defined:
  - Any arrival gate with arr_valid[g] && arr_data[g*PKT_W+VIP_BIT] beats retrieval and beats the starvation logic.
  - Among multiple VIP gates, round-robin from rr_ptr applies.
  - A VIP grant clears starve_cnt and updates rr_ptr normally.
- Undefined: VIP_BIT is ignored and behaviour is exactly as above.

Test Plan:
1. Reset and idle: rst_n low mid-HOLD_ARR → all outputs 0 immediately. After release with no requests → valids stay 0, grant_gate=0.
2. Round-robin: gates 0-3 all valid, valet_ready=1 constant, no retrieval → arr_ready one-hot sequence g0,g1,g2,g3,g0. arrival_info tracks each packet one cycle later, back-to-back.
3. Retrieval priority plus starvation (STARVE_LIMIT=4): ret_valid and arr_valid[2] held high, valet_ready=1 → four retrieval grants, then gate 2 granted, then retrieval again. starve_cnt sequence 1,2,3,4,0,1.
4. Backpressure: arrival held with valet_ready=0 for 5 cycles → arrival_info stable, no readies asserted. On valet_ready=1 with ret_valid pending → retrieval accepted that same cycle, retrieval_valid=1 next cycle, arrival_valid=0.
5. Withdrawal: arr_valid[1] pulsed during HOLD_RET with valet_ready=0 → no grant, rr_ptr and starve_cnt unchanged.
6. With VALET_VIP_BYPASS_EN: ret_valid=1, gate 3 VIP packet (bit31=1) → gate 3 granted first, starve_cnt=0. Without the macro → retrieval granted first.
